// File: rtl/inst_encoder_loader.sv
// Packs decoded RV32I instruction fields into an instruction word and streams
// the words into instruction memory at an auto-incrementing byte address.

package inst_encoder_loader_pkg;
    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE,
        S_TYPE,
        B_TYPE,
        U_TYPE,
        J_TYPE,
        INVALID_TYPE
    } inst_format_e;
endpackage

module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  inst_format_e      format_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [4:0]        rd_i,
    input  logic [31:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_FORMAT    = 2'd1;
    localparam logic [1:0] ERR_RANGE     = 2'd2;
    localparam logic [1:0] ERR_MISALIGN  = 2'd3;

    typedef enum logic {
        IDLE,
        WRITE
    } state_e;

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word_c;
    logic [1:0]        code_c;
    logic              fits_11_c;
    logic              fits_12_c;
    logic              fits_20_c;
    logic              accept_c;

    // Immediate sign-extension checks: upper bits must all equal the encoded sign bit
    assign fits_11_c = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits_12_c = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fits_20_c = (&imm_i[31:20]) | ~(|imm_i[31:20]);

    // Bundles are only taken while idle and not being restarted or reset
    assign ready_o  = (state == IDLE) && !start_i && !rst_i;
    assign accept_c = valid_i && ready_o;

    // Pack the fields for the selected format and classify encode errors
    always_comb begin
        word_c = 32'd0;
        code_c = ERR_NONE;
        unique case (format_i)
            R_TYPE: word_c = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            I_TYPE: begin
                word_c = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                if (!fits_11_c) code_c = ERR_RANGE;
            end
            S_TYPE: begin
                word_c = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                if (!fits_11_c) code_c = ERR_RANGE;
            end
            B_TYPE: begin
                word_c = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
                if (imm_i[0])        code_c = ERR_MISALIGN;
                else if (!fits_12_c) code_c = ERR_RANGE;
            end
            U_TYPE: begin
                word_c = {imm_i[31:12], rd_i, opcode_i};
                if (|imm_i[11:0]) code_c = ERR_MISALIGN;
            end
            J_TYPE: begin
                word_c = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                if (imm_i[0])        code_c = ERR_MISALIGN;
                else if (!fits_20_c) code_c = ERR_RANGE;
            end
            default: code_c = ERR_FORMAT;
        endcase
    end

    // Loader FSM: accept a bundle, hold the write until memory takes it, then advance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ptr         <= '0;
            count_o     <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
        end else if (start_i) begin
            state      <= IDLE;
            ptr        <= {base_addr_i[ADDR_W-1:2], 2'b00};
            count_o    <= '0;
            mem_we_o   <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (code_c == ERR_NONE) begin
                            state       <= WRITE;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= ptr;
                            mem_wdata_o <= word_c;
                        end else if (!err_o) begin
                            err_o      <= 1'b1;
                            err_code_o <= code_c;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready_i) begin
                        state    <= IDLE;
                        mem_we_o <= 1'b0;
                        ptr      <= ptr + ADDR_W'(4);
                        count_o  <= count_o + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: hand-packed RV32I words, stalls,
// encode errors, restart/reset during a write and pointer wrap.

module tb_inst_encoder_loader;
    import inst_encoder_loader_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  base_addr;
    logic         valid;
    logic         ready;
    logic         ready8;
    inst_format_e fmt;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [4:0]   rs1, rs2, rd;
    logic [31:0]  imm;
    logic         mem_we, mem_we8;
    logic [31:0]  mem_addr;
    logic [7:0]   mem_addr8;
    logic [31:0]  mem_wdata, mem_wdata8;
    logic         mem_ready;
    logic [15:0]  count, count8;
    logic         err, err8;
    logic [1:0]   err_code, err_code8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_encoder_loader dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
        .valid_i(valid), .ready_o(ready), .format_i(fmt), .opcode_i(opcode),
        .funct3_i(funct3), .funct7_i(funct7), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .imm_i(imm), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .count_o(count), .err_o(err), .err_code_o(err_code)
    );

    // Narrow-pointer instance sharing the same stimulus, used for the wrap case
    inst_encoder_loader #(.ADDR_W(8), .CNT_W(16)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr[7:0]),
        .valid_i(valid), .ready_o(ready8), .format_i(fmt), .opcode_i(opcode),
        .funct3_i(funct3), .funct7_i(funct7), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .imm_i(imm), .mem_we_o(mem_we8), .mem_addr_o(mem_addr8), .mem_wdata_o(mem_wdata8),
        .mem_ready_i(mem_ready), .count_o(count8), .err_o(err8), .err_code_o(err_code8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start = 1'b0;
    endtask

    // Present one bundle once ready_o is high; returns one cycle after acceptance
    task automatic send(input inst_format_e f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic [31:0] im);
        int n;
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rs1 = r1; rs2 = r2; rd = d; imm = im;
        n = 0;
        #1;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(ready), 32'd1);
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    // Send a bundle with memory always ready and check the single write cycle
    task automatic write_one(input inst_format_e f, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [4:0] d, input logic [31:0] im,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data,
                             input string tag);
        mem_ready = 1'b1;
        send(f, op, f3, f7, r1, r2, d, im);
        check({tag, "_we"},   32'(mem_we), 32'd1);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_data"}, mem_wdata, exp_data);
        tick();
        check({tag, "_we_drop"}, 32'(mem_we), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; valid = 1'b0;
        fmt = R_TYPE; opcode = '0; funct3 = '0; funct7 = '0;
        rs1 = '0; rs2 = '0; rd = '0; imm = '0; mem_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_we",    32'(mem_we), 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_data",  mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err",   {29'd0, err, err_code}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(ready), 32'd1);

        // Single ADDI x1,x0,5
        do_start(32'h0000_0100);
        write_one(I_TYPE, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5,
                  32'h100, 32'h0050_0093, "addi");
        check("addi_count", 32'(count), 32'd1);

        // Back-to-back stream
        do_start(32'h0000_0103);
        write_one(R_TYPE, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF,
                  32'h100, 32'h0020_81B3, "add");
        write_one(S_TYPE, 7'h23, 3'd2, 7'h7F, 5'd1, 5'd2, 5'd0, 32'd8,
                  32'h104, 32'h0020_A423, "sw");
        write_one(B_TYPE, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC,
                  32'h108, 32'hFE20_8EE3, "beq");
        write_one(J_TYPE, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8,
                  32'h10C, 32'h0080_00EF, "jal");
        write_one(U_TYPE, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000,
                  32'h110, 32'h1234_52B7, "lui");
        check("stream_count", 32'(count), 32'd5);

        // Memory stall for 3 cycles
        mem_ready = 1'b0;
        send(I_TYPE, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            check("stall_we",    32'(mem_we), 32'd1);
            check("stall_addr",  mem_addr, 32'h114);
            check("stall_data",  mem_wdata, 32'h0050_0093);
            check("stall_ready", 32'(ready), 32'd0);
            check("stall_count", 32'(count), 32'd5);
            tick();
        end
        check("stall_we_drop", 32'(mem_we), 32'd0);
        check("stall_count_inc", 32'(count), 32'd6);

        // Range error latched first, later misalign ignored
        send(I_TYPE, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
        check("range_err",  {30'd0, err_code}, 32'd2);
        check("range_flag", 32'(err), 32'd1);
        check("range_nowr", 32'(mem_we), 32'd0);
        send(B_TYPE, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3);
        check("sticky_code", {30'd0, err_code}, 32'd2);
        check("sticky_count", 32'(count), 32'd6);
        do_start(32'h0000_0200);
        check("start_clr", {29'd0, err, err_code}, 32'd0);
        send(B_TYPE, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3);
        check("misalign_code", {30'd0, err_code}, 32'd3);
        check("misalign_nowr", 32'(mem_we), 32'd0);

        // Invalid format
        do_start(32'h0000_0200);
        send(INVALID_TYPE, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd0);
        check("invalid_code", {29'd0, err, err_code}, 32'd5);
        check("invalid_nowr", 32'(mem_we), 32'd0);
        // J range and U misalign are also rejected without writing (error already latched)
        send(J_TYPE, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0010_0000);
        check("j_range_nowr", 32'(mem_we), 32'd0);
        check("invalid_count", 32'(count), 32'd0);
        do_start(32'h0000_0200);
        send(U_TYPE, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h0000_0800);
        check("u_misalign", {30'd0, err_code}, 32'd3);
        do_start(32'h0000_0200);
        send(J_TYPE, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0010_0000);
        check("j_range", {30'd0, err_code}, 32'd2);

        // Pointer wrap on the 8-bit instance
        do_start(32'h0000_00FC);
        mem_ready = 1'b1;
        send(I_TYPE, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        check("wrap_addr0", 32'(mem_addr8), 32'hFC);
        tick();
        send(I_TYPE, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        check("wrap_addr1", 32'(mem_addr8), 32'h00);
        check("wide_addr1", mem_addr, 32'h100);
        tick();
        check("wrap_count", 32'(count8), 32'd2);

        // Restart during a stalled write
        mem_ready = 1'b0;
        send(I_TYPE, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        check("abort_we_pre", 32'(mem_we), 32'd1);
        mem_ready = 1'b1;
        do_start(32'h0000_0300);
        check("abort_we",    32'(mem_we), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        write_one(R_TYPE, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0,
                  32'h300, 32'h0020_81B3, "after_abort");

        // Reset during a stalled write
        mem_ready = 1'b0;
        send(I_TYPE, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        check("rstw_we_pre", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rstw_ready", 32'(ready), 32'd0);
        tick();
        check("rstw_we",    32'(mem_we), 32'd0);
        check("rstw_addr",  mem_addr, 32'd0);
        check("rstw_data",  mem_wdata, 32'd0);
        check("rstw_count", 32'(count), 32'd0);
        rst = 1'b0;
        write_one(I_TYPE, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5,
                  32'h0, 32'h0050_0093, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Reverse direction of the instruction decoder. Accepts decoded instruction fields (format, opcode, funct3/7, register indices, full 32-bit immediate), packs them into an RV32I instruction word, and writes the word to instruction memory at an auto-incrementing address. Used by the program loader and self-test path to fill instruction memory before the core runs. Immediates that cannot be encoded are rejected with a sticky error code.

Parameters:
ADDR_W, 32, width of memory byte address / write pointer
CNT_W, 16, width of committed-instruction counter

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
start_i  input  1  begin new program: load pointer, clear count/error
base_addr_i  input  ADDR_W  load address; bits [1:0] ignored (forced 0)
valid_i  input  1  field bundle valid
ready_o  output  1  bundle accepted when valid_i && ready_o
format_i  input  inst_format_e  R/I/S/B/U/J/INVALID_TYPE
opcode_i  input  7  opcode, inserted verbatim
funct3_i  input  3  funct3
funct7_i  input  7  funct7 (R_TYPE only)
rs1_i  input  5  source reg 1
rs2_i  input  5  source reg 2
rd_i  input  5  destination reg
imm_i  input  32  full sign-extended immediate value, as the decoder emits it
mem_we_o  output  1  write request
mem_addr_o  output  ADDR_W  write byte address
mem_wdata_o  output  32  encoded word
mem_ready_i  input  1  memory accepts write this cycle
count_o  output  CNT_W  instructions written since start/reset
err_o  output  1  sticky encode error
err_code_o  output  2  0 none, 1 invalid format, 2 imm out of range, 3 imm misaligned

Behaviour:
- Reset: state IDLE, pointer 0, count_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, err_o 0, err_code_o 0; ready_o 0 during reset cycle.
- FSM: IDLE, WRITE.
- IDLE: ready_o = !start_i. Accept -> encode combinationally, register word.
- Valid bundle: next cycle WRITE, mem_we_o=1, mem_addr_o=pointer, mem_wdata_o=word.
- Encode-error bundle: accepted, no write; stay IDLE. If err_o=0: err_o<=1 and err_code_o<=code next cycle. First error only latched.
- WRITE: mem_we_o/addr/wdata held stable until mem_ready_i=1. In the cycle mem_ready_i=1 is sampled: pointer+=4 (wraps modulo 2^ADDR_W), count_o+=1 (wraps modulo 2^CNT_W), state->IDLE, mem_we_o=0 next cycle. ready_o=0 throughout WRITE.
- Peak throughput: one word per 2 cycles.
- start_i (any state, priority over everything except rst_i): pointer<=base_addr_i & ~3, count_o<=0, err_o<=0, err_code_o<=0, state<=IDLE, mem_we_o<=0. Pending write is aborted and not counted. mem_ready_i in same cycle is ignored.
- Packing (o=opcode_i, f3=funct3_i):
  - R: {funct7,rs2,rs1,f3,rd,o}
  - I: {imm[11:0],rs1,f3,rd,o}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],o}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],o}
  - U: {imm[31:12],rd,o}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,o}
- Checks, code 3 has priority over code 2:
  - INVALID_TYPE: code 1.
  - I/S: imm[31:11] must be all-equal, else code 2.
  - B: imm[0]!=0 -> code 3; else imm[31:12] not all-equal -> code 2.
  - J: imm[0]!=0 -> code 3; else imm[31:20] not all-equal -> code 2.
  - U: imm[11:0]!=0 -> code 3.
  - R: imm ignored.
- Unused fields of a format are ignored (no error).
- Opcode/format consistency is not checked.

Test Plan:
- Reset, start_i with base 0x100; send ADDI x1,x0,5 (I, op 0x13, f3 0, imm 5) with mem_ready_i=1 -> one write cycle, addr 0x100, data 0x00500093, count_o 1.
- Back-to-back stream, each bundle sent when ready_o is high: ADD x3,x1,x2 (R) -> 0x002081B3 @0x100; SW x2,8(x1) -> 0x0020A423 @0x104; BEQ x1,x2,-4 -> 0xFE208EE3 @0x108; JAL x1,8 -> 0x008000EF @0x10C; LUI x5 imm 0x12345000 -> 0x123452B7 @0x110; count_o 5.
- mem_ready_i held low 3 cycles -> mem_we_o/addr/data stable for 4 cycles, ready_o 0; single increment on acceptance.
- I imm 2048 -> err_o 1, code 2, no write. Then B imm 3 -> code stays 2. New start_i -> err cleared. B imm 3 -> code 3.
- INVALID_TYPE -> code 1, no write. Pointer wrap: ADDR_W=8, base 0xFC, two writes -> addresses 0xFC then 0x00.
- start_i asserted during WRITE with mem_ready_i low -> mem_we_o 0 next cycle, count_o 0, pointer = new base; rst_i mid-WRITE -> all outputs reset values.
